// File: rtl/xdff_bank_if.sv
// Control, data and status bundle for the xdff_bank register cell.
// The master side drives control/data; the slave side returns register state.
interface xdff_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Rs;
  logic             S;
  logic             En;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] D0;
  logic             Sin;
  logic [WIDTH-1:0] Q0;
  logic             Sout;
  logic             Tc;
  logic             Wrap;

  modport master (
    output Rs, S, En, Mode, D0, Sin,
    input  Q0, Sout, Tc, Wrap
  );

  modport slave (
    input  Rs, S, En, Mode, D0, Sin,
    output Q0, Sout, Tc, Wrap
  );
endinterface

// File: rtl/xdff_bank.sv
// WIDTH-bit storage/counting cell: async reset, sync reset/set, enable, and
// load/shift/rotate/up-down count modes with terminal count and wrap pulse.
module xdff_bank #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter logic [WIDTH-1:0]      SET_VAL   = '1
) (
  input  logic        clk0,
  input  logic        Ra,
  xdff_bank_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_UP   = 3'b100,
    MODE_DN   = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_ROR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_tc;
  logic             w_sout;
  mode_e            w_mode;

  assign w_mode = mode_e'(bus.Mode);

  // Terminal count: counter sits at the value the next advance wraps from
  always_comb begin
    w_tc = 1'b0;
    if (bus.En) begin
      case (w_mode)
        MODE_UP: w_tc = (r_q == '1);
        MODE_DN: w_tc = (r_q == '0);
        default: w_tc = 1'b0;
      endcase
    end
  end

  // Serial out shows the bit about to leave; independent of En
  always_comb begin
    w_sout = 1'b0;
    case (w_mode)
      MODE_SHL, MODE_ROL: w_sout = r_q[WIDTH-1];
      MODE_SHR, MODE_ROR: w_sout = r_q[0];
      default:            w_sout = 1'b0;
    endcase
  end

  // Next state: Rs > S > hold (En = 0) > mode operation
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (bus.Rs) begin
      w_q_nxt = RESET_VAL;
    end else if (bus.S) begin
      w_q_nxt = SET_VAL;
    end else if (bus.En) begin
      case (w_mode)
        MODE_HOLD: w_q_nxt = r_q;
        MODE_LOAD: w_q_nxt = bus.D0;
        MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], bus.Sin};
        MODE_SHR:  w_q_nxt = {bus.Sin, r_q[WIDTH-1:1]};
        MODE_UP: begin
          w_q_nxt    = r_q + WIDTH'(1);
          w_wrap_nxt = w_tc;
        end
        MODE_DN: begin
          w_q_nxt    = r_q - WIDTH'(1);
          w_wrap_nxt = w_tc;
        end
        MODE_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        default:   w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk0 or posedge Ra) begin
    if (Ra) begin
      r_q    <= RESET_VAL;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.Q0   = r_q;
  assign bus.Wrap = r_wrap;
  assign bus.Sout = w_sout;
  assign bus.Tc   = w_tc;

endmodule

// File: doc/xdff_bank.md
# xdff_bank

Parametrised successor to the single-bit D flip-flop with async reset, sync set and sync reset. A WIDTH-bit register cell with the same reset/set control set, plus enable and an operating-mode selector (load, shift, rotate, up/down count). It is the general-purpose storage/counting element for the g5 sequential blocks, replacing ad-hoc chains of single-bit flops.

## Interface

Parameters:
- WIDTH, 8, register width in bits (legal range 2..32)
- RESET_VAL, 0, value loaded by Ra (async) and Rs (sync)
- SET_VAL, all ones ({WIDTH{1'b1}}), value loaded by S (sync)

Ports:
- clk0  input  1  clock; all state updates on rising edge
- Ra  input  1  asynchronous reset, active-high; forces Q0 = RESET_VAL, Wrap = 0 immediately
- Rs  input  1  synchronous reset, active-high
- S  input  1  synchronous set, active-high
- En  input  1  mode-operation enable; Rs/S act regardless of En
- Mode  input  3  operation select (see Operation)
- D0  input  WIDTH  parallel load data
- Sin  input  1  serial input for shift modes
- Q0  output  WIDTH  register contents
- Sout  output  1  serial output (combinational from Q0 and Mode)
- Tc  output  1  terminal count (combinational)
- Wrap  output  1  registered one-cycle pulse: counter wrapped on previous edge

## Operation

- Priority at each rising clk0: Ra (async, overrides everything) > Rs > S > En = 0 (hold) > Mode.
- Rs and S both high: Rs wins, Q0 = RESET_VAL.
- Mode encoding (effective only with En = 1, Rs = 0, S = 0):
  - 000 hold
  - 001 load: Q0 <= D0
  - 010 shift left: Q0 <= {Q0[WIDTH-2:0], Sin}
  - 011 shift right: Q0 <= {Sin, Q0[WIDTH-1:1]}
  - 100 count up: Q0 <= Q0 + 1, modulo 2^WIDTH
  - 101 count down: Q0 <= Q0 - 1, modulo 2^WIDTH
  - 110 rotate left: Q0 <= {Q0[WIDTH-2:0], Q0[WIDTH-1]}
  - 111 rotate right: Q0 <= {Q0[0], Q0[WIDTH-1:1]}
- Sout = Q0[WIDTH-1] in modes 010/110; Q0[0] in modes 011/111; 0 in all other modes. Not gated by En.
- Tc = En & ((Mode == 100 & Q0 == all ones) | (Mode == 101 & Q0 == 0)); else 0.
- Wrap <= 1 on an edge where the counter actually advanced with Tc = 1 (all-ones -> 0 up, 0 -> all-ones down); else Wrap <= 0. Rs and S edges clear Wrap.
- Arithmetic strictly WIDTH bits; no carry out beyond Wrap.

## Timing

- Reset values: Q0 = RESET_VAL, Wrap = 0; Sout/Tc follow from Q0 and current inputs (Sout = 0 and Tc = 0 when Mode = 000).
- Ra assertion: Q0/Wrap change without waiting for clk0; held while Ra = 1 regardless of clock.
- Ra deassertion: first rising edge with Ra = 0 performs normal operation; no dead cycle.
- Ra asserted mid-count/mid-shift: partial state discarded, Q0 = RESET_VAL.
- Latency: all modes 1 cycle (Q0 valid after the edge); Wrap high exactly one cycle, coincident with the wrapped Q0.
- Tc and Sout are combinational: change in the same cycle as Mode/En/Q0.
- Mode or En changes take effect at the next edge; no pipeline state beyond Q0 and Wrap.

## Test plan

- Ra pulse while clk0 low, Q0 = 8'h5A -> Q0 = 8'h00 before next edge; Wrap = 0; release Ra, Mode = 001, D0 = 8'hC3 -> Q0 = 8'hC3 after one edge.
- Rs = 1, S = 1, En = 0 at one edge from Q0 = 8'h3C -> Q0 = 8'h00; then S only -> Q0 = 8'hFF.
- Mode = 100, En = 1 from Q0 = 8'hFE -> FF with Tc = 1, then 00 with Wrap = 1 for one cycle, then 01 with Wrap = 0; En = 0 for two edges -> Q0 holds 01, Tc = 0.
- Mode = 101 from 8'h01 -> 00 (Tc = 1), FF with Wrap = 1.
- Mode = 010, Sin sequence 1,0,1,1 from 8'h00 -> Q0 = 8'h0B; Sout tracks Q0[7] (0); Mode = 011, Sin = 1 -> Q0 = 8'h85, Sout = Q0[0] = 1.
- Mode = 110 from 8'h81 -> 8'h03; Mode = 111 from 8'h81 -> 8'hC0; eight rotates in either direction return original value.
